imem_loader: RTL and testbench
==============================

# imem_loader

Serial program loader for the single-cycle MIPS core: it receives a program over a UART line and writes it into the instruction memory. It is the write-side counterpart of the core's instruction fetch path. While a load is in progress it holds the CPU in reset, then releases it with the program counter starting from word 0. It sits beside the core's instruction memory, drives that memory's write port, and feeds the core's reset through `cpu_hold`.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency of `clk_fpga`.
- `BAUD`, default 115_200: UART bit rate. Bit period `CLKS_PER_BIT = CLK_HZ/BAUD`, integer-truncated; it must be at least 4.
- `ADDR_W`, default 8: instruction-memory word-address width.
- `TIMEOUT_BITS`, default 20: inter-byte timeout, measured in bit periods.

Ports:
- `clk_fpga`  in  1  system clock.
- `n_reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial input, idle high; asynchronous to `clk_fpga`.
- `start`  in  1  one-cycle pulse that arms a load; ignored while `busy`.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the current write.
- `imem_wdata`  out  32  instruction word to write.
- `cpu_hold`  out  1  high keeps the core in reset.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed successfully; sticky until the next `start`.
- `err`  out  1  the last load failed; sticky until the next `start`.
- `words_loaded`  out  ADDR_W+1  number of words written in the current or last load.

## Operation
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0, `words_loaded`=0, state IDLE.
- **Receiver.** `uart_rx` passes through a 2-FF synchronizer. A falling edge starts a frame.
  - The start bit is re-sampled at `CLKS_PER_BIT/2`; if it reads high, the edge was a glitch and the receiver returns to idle.
  - The 8 data bits are then sampled LSB-first at mid-bit, followed by the stop bit.
  - A stop bit of 0 is a framing error.
- **Stream format.** Two count bytes give N, big-endian. N words follow, each sent as 4 bytes, MSB first.
- **State machine.**
  - IDLE: `start` clears `done`, `err` and `words_loaded`, sets `cpu_hold` and `busy`, and moves to CNT_HI.
  - CNT_HI: on a byte, store `N[15:8]` and move to CNT_LO.
  - CNT_LO: on a byte, store `N[7:0]`. If N=0, go to DONE. If N > 2^ADDR_W, go to ERR. Otherwise go to DATA.
  - DATA: shift each byte into a 32-bit assembler. On the 4th byte, pulse `imem_we` and increment `words_loaded`. When `words_loaded` reaches N, go to DONE; otherwise stay in DATA.
  - DONE: set `done`, clear `busy` and `cpu_hold`, return to IDLE.
  - ERR: set `err`, clear `busy`, keep `cpu_hold`=1 (the memory contents are invalid), return to IDLE.
- **Error sources.** Any of the following while `busy` sends the machine to ERR:
  - a framing error;
  - a count overflow;
  - no new start bit within `TIMEOUT_BITS` bit periods after the previous stop bit.
- **Write addressing.** `imem_addr` equals `words_loaded` truncated to ADDR_W bits, giving 0, 1, ... N-1. It wraps only at N = 2^ADDR_W, after the final write.
- **Re-arming.** `cpu_hold` stays high after an error until a later load succeeds. `start` received in IDLE after ERR re-arms the loader.
- **Reset mid-load.** Asserting `n_reset` aborts immediately and returns every output to its reset value, so `cpu_hold`=0. Words already written stay in memory.

## Timing
- A byte is valid one cycle after its stop-bit sample.
- `imem_we`, `imem_addr` and `imem_wdata` are registered together, in the cycle after the 4th byte of a word becomes valid.
- After the final write, `done` rises and `cpu_hold` falls one cycle later.
- `err` rises one cycle after the detecting event.
- A `start` pulse in the same cycle as DONE→IDLE is ignored; it is accepted only in IDLE.
- No back-pressure: every received byte is consumed in the cycle it becomes valid.

## Structure
- Package `imem_loader_pkg`: state enum (IDLE, CNT_HI, CNT_LO, DATA, DONE, ERR), the `CLKS_PER_BIT` function, and the stop-bit and idle-level constants.
- Sub-module `uart_rx_byte`:
  - contains the synchronizer, bit timer and shift register;
  - outputs `rx_data[7:0]`, `rx_valid` (1-cycle pulse), `rx_ferr` (1-cycle pulse), and `rx_idle_cnt` for the timeout.
- The top level holds the FSM, word assembler and counters.

## Test plan
All scenarios use `CLK_HZ`=1_000_000, `BAUD`=100_000 (10 clocks per bit), `ADDR_W`=4.
- Normal load: `start`, then bytes 00 02 20 08 00 05 AC 09 00 04 → writes 0x20080005 at addr 0 and 0xAC090004 at addr 1; `done`=1, `words_loaded`=2, `cpu_hold` falls 1 cycle after `done`.
- N=0: `start`, then 00 00 → no `imem_we`; `done`=1; `cpu_hold`=0.
- Overflow: `start`, then 00 11 (N=17 > 16) → `err`=1, `cpu_hold`=1, no writes.
- Framing error: 3rd data byte sent with stop bit 0 → `err`=1, `busy`=0, `words_loaded` unchanged.
- Glitch and timeout:
  - a 3-clock low pulse on `uart_rx` produces no byte;
  - a stream stopped after 5 bytes gives `err`=1 exactly 20 bit periods after the 5th stop bit.
- Reset mid-DATA: assert `n_reset` after the 2nd word → all outputs return to 0 asynchronously. A fresh `start` and a full stream then load successfully from addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds the loader state encoding, the bit-period helper and the line-level constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int CLKS_PER_BIT(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: byte/framing pulses one cycle after the stop-bit sample; no back-pressure.
// Also reports clocks spent idle since the last stop bit (saturating) for the loader timeout.
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int CPB          = 434,
    parameter int TIMEOUT_CLKS = 8680,
    parameter int IDLE_W       = $clog2(TIMEOUT_CLKS + 1)
) (
    input  logic              clk_fpga,
    input  logic              n_reset,
    input  logic              uart_rx,
    input  logic              idle_clr,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              rx_ferr,
    output logic [IDLE_W-1:0] rx_idle_cnt
);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    localparam int                CNT_W     = $clog2(CPB);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CLKS);

    logic [1:0]        sync_q;
    logic              prev_q;
    rx_state_t         rstate_q, rstate_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_fpga or negedge n_reset) begin
        if (!n_reset) begin
            sync_q   <= {2{IDLE_LEVEL}};
            prev_q   <= IDLE_LEVEL;
            rstate_q <= R_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            idle_q   <= '0;
        end else begin
            sync_q   <= {sync_q[0], uart_rx};
            prev_q   <= rx_s;
            rstate_q <= rstate_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            idle_q   <= idle_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        idle_d   = idle_q;
        if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
        case (rstate_q)
            R_IDLE: begin
                if (prev_q == IDLE_LEVEL && rx_s != IDLE_LEVEL) begin
                    rstate_d = R_START;
                    cnt_d    = '0;
                end
            end
            R_START: begin
                // A start bit that is high again at half-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s == IDLE_LEVEL) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rstate_d = R_DATA;
                        bit_d    = '0;
                        idle_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                idle_d = '0;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rstate_d = R_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                idle_d = '0;
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    rstate_d = R_IDLE;
                    if (rx_s == STOP_BIT) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        if (idle_clr) begin
            idle_d = '0;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_ferr     = ferr_q;
    assign rx_idle_cnt = idle_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a count-prefixed program from UART into instruction memory, holding the CPU in reset meanwhile.
// Write strobe lands one cycle after the 4th byte of a word; no back-pressure, every byte consumed on arrival.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk_fpga,
    input  logic              n_reset,
    input  logic              uart_rx,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          CPB     = CLKS_PER_BIT(CLK_HZ, BAUD);
    localparam int          TO_CLKS = TIMEOUT_BITS * CPB;
    localparam int          IDLE_W  = $clog2(TO_CLKS + 1);
    localparam logic [31:0] N_MAX   = 32'd1 << ADDR_W;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ferr;
    logic [IDLE_W-1:0] rx_idle_cnt;
    logic              idle_clr;

    uart_rx_byte #(
        .CPB          (CPB),
        .TIMEOUT_CLKS (TO_CLKS),
        .IDLE_W       (IDLE_W)
    ) u_rx (
        .clk_fpga    (clk_fpga),
        .n_reset     (n_reset),
        .uart_rx     (uart_rx),
        .idle_clr    (idle_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ferr     (rx_ferr),
        .rx_idle_cnt (rx_idle_cnt)
    );

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [15:0]       n_full;
    logic              fault;

    assign n_full = {n_q[15:8], rx_data};
    // err must rise exactly TO_CLKS after the stop-bit sample, hence the -1.
    assign fault  = rx_ferr || (rx_idle_cnt >= IDLE_W'(TO_CLKS - 1));

    always_ff @(posedge clk_fpga or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        bcnt_d   = bcnt_q;
        asm_d    = asm_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        wl_d     = wl_q;
        idle_clr = 1'b0;
        // Releasing the core one cycle after done keeps the final write settled first.
        if (done_q) begin
            hold_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    wl_d     = '0;
                    hold_d   = 1'b1;
                    busy_d   = 1'b1;
                    idle_clr = 1'b1;
                    state_d  = CNT_HI;
                end
            end
            CNT_HI: begin
                if (fault) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (rx_valid) begin
                    n_d[15:8] = rx_data;
                    state_d   = CNT_LO;
                end
            end
            CNT_LO: begin
                if (fault) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (rx_valid) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({16'd0, n_full} > N_MAX) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        bcnt_d  = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fault) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else if (rx_valid) begin
                    asm_d  = {asm_q[15:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wl_q[ADDR_W-1:0];
                        wdata_d = {asm_q, rx_data};
                        wl_d    = wl_q + 1'b1;
                        if (32'(wl_q) + 32'd1 == 32'(n_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent and a
// separate monitor checks every imem_we strobe against the queue.
module tb_imem_loader;

    localparam int CPB = 10;
    localparam int AW  = 4;

    logic          clk_fpga = 1'b0;
    logic          n_reset  = 1'b0;
    logic          uart_rx  = 1'b1;
    logic          start    = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  cyc      = 0;
    int  stop_cyc = 0;

    imem_loader #(
        .CLK_HZ       (1_000_000),
        .BAUD         (100_000),
        .ADDR_W       (AW),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk_fpga     (clk_fpga),
        .n_reset      (n_reset),
        .uart_rx      (uart_rx),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk_fpga = ~clk_fpga;
    always @(posedge clk_fpga) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk_fpga) begin
        if (n_reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk_fpga);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1);
        @(posedge clk_fpga);
        #1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        stop_cyc = cyc;
        send_bit(stop_v);
        uart_rx = 1'b1;
    endtask

    task automatic send_count(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk_fpga);
        #1 start = 1'b1;
        @(posedge clk_fpga);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        @(negedge clk_fpga);
        while (!(done || err) && n < 50) begin
            @(negedge clk_fpga);
            n++;
        end
        checks++;
        if (!(done || err)) begin
            errors++;
            $display("FAIL %s_end: done=%0b err=%0b after 50 cycles, expected one of them set", name, done, err);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_we"}, 32'(imem_we), 0);
        chk({name, "_addr"}, 32'(imem_addr), 0);
        chk({name, "_wdata"}, imem_wdata, 0);
        chk({name, "_hold"}, 32'(cpu_hold), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_err"}, 32'(err), 0);
        chk({name, "_wl"}, 32'(words_loaded), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int delta;
        logic [31:0] w;

        repeat (3) @(posedge clk_fpga);
        #1 chk_all_zero("reset");
        @(negedge clk_fpga) n_reset = 1'b1;
        repeat (2) @(posedge clk_fpga);
        #1 chk_all_zero("post_reset");

        // Normal two-word load.
        pulse_start();
        chk("start_busy", 32'(busy), 1);
        chk("start_hold", 32'(cpu_hold), 1);
        expect_wr(0, 32'h2008_0005);
        expect_wr(1, 32'hAC09_0004);
        send_count(16'd2);
        send_word(32'h2008_0005);
        send_word(32'hAC09_0004);
        wait_end("normal");
        chk("normal_done", 32'(done), 1);
        chk("normal_err", 32'(err), 0);
        chk("normal_busy", 32'(busy), 0);
        chk("normal_wl", 32'(words_loaded), 2);
        chk("normal_hold_at_done", 32'(cpu_hold), 1);
        @(negedge clk_fpga);
        chk("normal_hold_after", 32'(cpu_hold), 0);
        chk("normal_sb_empty", exp_q.size(), 0);

        // Empty program.
        pulse_start();
        send_count(16'd0);
        wait_end("n0");
        chk("n0_done", 32'(done), 1);
        chk("n0_err", 32'(err), 0);
        chk("n0_wl", 32'(words_loaded), 0);
        repeat (2) @(negedge clk_fpga);
        chk("n0_hold", 32'(cpu_hold), 0);

        // Count one past memory size.
        pulse_start();
        send_count(16'd17);
        wait_end("ovf");
        chk("ovf_err", 32'(err), 1);
        chk("ovf_done", 32'(done), 0);
        chk("ovf_busy", 32'(busy), 0);
        chk("ovf_wl", 32'(words_loaded), 0);
        repeat (3) @(negedge clk_fpga);
        chk("ovf_hold", 32'(cpu_hold), 1);

        // Framing error on the 3rd data byte.
        pulse_start();
        chk("ferr_err_cleared", 32'(err), 0);
        send_count(16'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33, 1'b0);
        wait_end("ferr");
        chk("ferr_err", 32'(err), 1);
        chk("ferr_busy", 32'(busy), 0);
        chk("ferr_wl", 32'(words_loaded), 0);
        chk("ferr_hold", 32'(cpu_hold), 1);

        // Short low glitch must not be taken as a byte.
        pulse_start();
        @(posedge clk_fpga);
        #1 uart_rx = 1'b0;
        repeat (3) @(posedge clk_fpga);
        #1 uart_rx = 1'b1;
        repeat (30) @(posedge clk_fpga);
        expect_wr(0, 32'hDEAD_BEEF);
        send_count(16'd1);
        send_word(32'hDEAD_BEEF);
        wait_end("glitch");
        chk("glitch_done", 32'(done), 1);
        chk("glitch_err", 32'(err), 0);
        chk("glitch_wl", 32'(words_loaded), 1);
        repeat (2) @(negedge clk_fpga);
        chk("glitch_hold", 32'(cpu_hold), 0);
        chk("glitch_sb_empty", exp_q.size(), 0);

        // Stream stalls after 5 bytes: err 20 bit periods after the last stop bit.
        pulse_start();
        send_count(16'd2);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        while (!err && (cyc - stop_cyc) < 400) @(negedge clk_fpga);
        delta = cyc - stop_cyc;
        checks++;
        if (!err || delta < 200 || delta > 210) begin
            errors++;
            $display("FAIL timeout_latency: err=%0b at %0d cycles after stop bit start, expected err=1 at 200..210",
                     err, delta);
        end
        chk("to_busy", 32'(busy), 0);
        chk("to_hold", 32'(cpu_hold), 1);
        chk("to_wl", 32'(words_loaded), 0);

        // Full memory: 16 words, address wraps only after the last write.
        pulse_start();
        for (int i = 0; i < 16; i++) expect_wr(i, {8'(i), 8'hA5, 8'(i * 3), 8'h5A});
        send_count(16'd16);
        for (int i = 0; i < 16; i++) begin
            w = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
            send_word(w);
        end
        wait_end("full");
        chk("full_done", 32'(done), 1);
        chk("full_err", 32'(err), 0);
        chk("full_wl", 32'(words_loaded), 16);
        chk("full_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a load, then a clean reload.
        pulse_start();
        expect_wr(0, 32'h1111_2222);
        expect_wr(1, 32'h3333_4444);
        send_count(16'd3);
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        @(negedge clk_fpga);
        #2 n_reset = 1'b0;
        #1 chk_all_zero("rst_mid");
        chk("rst_sb_empty", exp_q.size(), 0);
        @(negedge clk_fpga) n_reset = 1'b1;
        pulse_start();
        expect_wr(0, 32'h0BAD_F00D);
        expect_wr(1, 32'h1234_5678);
        send_count(16'd2);
        send_word(32'h0BAD_F00D);
        send_word(32'h1234_5678);
        wait_end("reload");
        chk("reload_done", 32'(done), 1);
        chk("reload_err", 32'(err), 0);
        chk("reload_wl", 32'(words_loaded), 2);
        @(negedge clk_fpga);
        chk("reload_hold", 32'(cpu_hold), 0);
        chk("reload_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
